alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_seq_decode.sv | 61 ++++++
 rtl/alu_sequencer.sv | 100 ++++++++++
 tb/tb_alu_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, ALU control codes, branch funct3 codes and FSM states for the ALU sequencer
package alu_seq_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic v, input logic c);
        return (f3 == F3_BEQ)  ?  z :
               (f3 == F3_BNE)  ? !z :
               (f3 == F3_BLT)  ?  (n ^ v) :
               (f3 == F3_BGE)  ? !(n ^ v) :
               (f3 == F3_BLTU) ? !c :
               (f3 == F3_BGEU) ?  c : 1'b0;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshake bundle between a requester and the ALU sequencer
interface alu_sequencer_if #(parameter int XLEN = 32) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_branch_taken;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_result, out_branch_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_result, out_branch_taken, out_illegal
    );

endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational RV32I decode to ALU control, operand-B select, branch flag and legality
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [31:0] instr,
    output alu_ctrl_e   alu_ctrl,
    output logic        b_sel,
    output logic        is_branch,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       arith_ok;
    alu_ctrl_e  arith_ctrl;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // R and I types share one funct3 map; only R-type turns funct7[5] into subtract
    always_comb begin
        arith_ctrl = ALU_ADD;
        arith_ok   = 1'b1;
        case (f3)
            3'b000:  arith_ctrl = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  arith_ctrl = ALU_AND;
            3'b110:  arith_ctrl = ALU_OR;
            3'b010:  arith_ctrl = ALU_SLT;
            default: arith_ok   = 1'b0;
        endcase
    end

    // opcode picks operand source, branch handling and legality
    always_comb begin
        alu_ctrl  = ALU_ADD;
        b_sel     = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                alu_ctrl = arith_ctrl;
                illegal  = !arith_ok;
            end
            OP_I: begin
                alu_ctrl = arith_ctrl;
                b_sel    = 1'b1;
                illegal  = !arith_ok;
            end
            OP_LOAD, OP_STORE: b_sel = 1'b1;
            OP_BRANCH: begin
                alu_ctrl  = ALU_SUB;
                is_branch = 1'b1;
                illegal   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one decoded RV32I op to an external ALU and returns result/branch outcome;
// ALU_SEQUENCER_PERF_EN adds a completed-response counter on perf_count
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_n,
    input  logic            alu_v,
    input  logic            alu_c,
    output logic [31:0]     perf_count
);

    state_e          state, state_n;
    alu_ctrl_e       dec_ctrl, ctrl_q;
    logic            dec_b_sel, dec_branch, dec_illegal;
    logic            branch_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] result_q;
    logic            taken_q, illegal_q;
    logic            accept, done;

    alu_seq_decode u_decode (
        .instr     (bus.in_instr),
        .alu_ctrl  (dec_ctrl),
        .b_sel     (dec_b_sel),
        .is_branch (dec_branch),
        .illegal   (dec_illegal)
    );

    assign bus.in_ready         = (state == IDLE);
    assign bus.out_valid        = (state == RESP);
    assign bus.out_result       = result_q;
    assign bus.out_branch_taken = taken_q;
    assign bus.out_illegal      = illegal_q;
    assign alu_ctrl             = ctrl_q;
    assign accept               = bus.in_valid && bus.in_ready;
    assign done                 = bus.out_valid && bus.out_ready;

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // illegal requests skip the ALU cycle and respond straight away
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (dec_illegal ? RESP : ISSUE) : IDLE;
            ISSUE:   state_n = RESP;
            RESP:    state_n = done ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // latch operands on a legal accept, capture the ALU outcome at the end of ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            ctrl_q    <= ALU_ADD;
            branch_q  <= 1'b0;
            f3_q      <= 3'b000;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= dec_illegal;
            if (!dec_illegal) begin
                alu_a    <= bus.in_rs1;
                alu_b    <= dec_b_sel ? bus.in_imm : bus.in_rs2;
                ctrl_q   <= dec_ctrl;
                branch_q <= dec_branch;
                f3_q     <= bus.in_instr[14:12];
            end
        end else if (state == ISSUE) begin
            result_q <= alu_result;
            taken_q  <= branch_q && branch_taken(f3_q, alu_result == '0, alu_n, alu_v, alu_c);
        end
    end

`ifdef ALU_SEQUENCER_PERF_EN
    // count every accepted response, wrapping naturally
    always_ff @(posedge clk) begin
        perf_count <= rst ? '0 : perf_count + 32'(done);
    end
`else
    assign perf_count = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural external ALU
module tb_alu_sequencer;

    typedef struct {
        logic [31:0] result;
        logic        taken;
        logic        illegal;
        logic [2:0]  ctrl;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        int          hold;
    } req_t;

`ifdef ALU_SEQUENCER_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam int NREQ = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_a, alu_b, alu_result, perf_count;
    logic [2:0]  alu_ctrl;
    logic        alu_n, alu_v, alu_c;
    logic [32:0] sum;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_done = 0;
    exp_t        sb[$];

    req_t tbl[NREQ] = '{
        '{32'h002081B3, 32'd5,        32'd7,        32'd0,        0},
        '{32'h402081B3, 32'd3,        32'd5,        32'd0,        0},
        '{32'h0020F1B3, 32'h0000F0F0, 32'h00000FF0, 32'd0,        0},
        '{32'h0000007F, 32'd1,        32'd2,        32'd3,        5},
        '{32'h0020E063, 32'd1,        32'hFFFFFFFF, 32'd0,        0},
        '{32'h0020C063, 32'd1,        32'hFFFFFFFF, 32'd0,        1},
        '{32'h00208063, 32'd9,        32'd9,        32'd0,        0},
        '{32'h00209063, 32'd9,        32'd9,        32'd0,        0},
        '{32'h0020D063, 32'h80000000, 32'd1,        32'd0,        0},
        '{32'h0020F063, 32'h80000000, 32'd1,        32'd0,        0},
        '{32'h40008193, 32'd10,       32'd0,        32'hFFFFFFFC, 0},
        '{32'h0000F193, 32'h000000FF, 32'd0,        32'h0000000F, 0},
        '{32'h0000E193, 32'h000000F0, 32'd0,        32'h0000000F, 0},
        '{32'h0000A193, 32'hFFFFFFFF, 32'd0,        32'd0,        0},
        '{32'h0020E1B3, 32'h0000000A, 32'd5,        32'd0,        0},
        '{32'h0020A1B3, 32'd5,        32'hFFFFFFFF, 32'd0,        0},
        '{32'h0000A183, 32'h00000100, 32'd999,      32'h00000020, 0},
        '{32'h0020A023, 32'h00000100, 32'd999,      32'hFFFFFFF0, 0},
        '{32'h002091B3, 32'd4,        32'd4,        32'd4,        2},
        '{32'h0020A063, 32'd4,        32'd4,        32'd0,        0}
    };

    alu_sequencer_if #(.XLEN(32)) bus ();

    alu_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_n      (alu_n),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .perf_count (perf_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external ALU: add/sub report carry and signed overflow, logic ops clear them
    always_comb begin
        sum        = 33'd0;
        alu_result = 32'd0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[31:0];
                alu_c      = sum[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b001: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = sum[31:0];
                alu_c      = sum[32];
                alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_n = alu_result[31];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a,
                                   input logic [31:0] b2, input logic [31:0] imm);
        exp_t        e;
        logic [6:0]  op = instr[6:0];
        logic [2:0]  f3 = instr[14:12];
        logic [31:0] b  = (op == 7'h33) ? b2 : imm;
        e = '{32'd0, 1'b0, 1'b1, 3'b000};
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: begin
                    e.illegal = 1'b0;
                    e.ctrl    = (op == 7'h33 && instr[30]) ? 3'b001 : 3'b000;
                    e.result  = (e.ctrl == 3'b001) ? a - b : a + b;
                end
                3'd7: e = '{a & b, 1'b0, 1'b0, 3'b010};
                3'd6: e = '{a | b, 1'b0, 1'b0, 3'b011};
                3'd2: e = '{{31'd0, $signed(a) < $signed(b)}, 1'b0, 1'b0, 3'b101};
                default: ;
            endcase
        end else if (op == 7'h03 || op == 7'h23) begin
            e = '{a + imm, 1'b0, 1'b0, 3'b000};
        end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            e = '{a - b2, 1'b0, 1'b0, 3'b001};
            case (f3)
                3'd0:    e.taken = (a == b2);
                3'd1:    e.taken = (a != b2);
                3'd4:    e.taken = ($signed(a) < $signed(b2));
                3'd5:    e.taken = ($signed(a) >= $signed(b2));
                3'd6:    e.taken = (a < b2);
                default: e.taken = (a >= b2);
            endcase
        end
        return e;
    endfunction

    task automatic run_req(input req_t r);
        exp_t        e;
        int          t0;
        int          seen;
        logic [31:0] pa, pb, sr;
        logic [2:0]  pc;
        logic        st, si;
        e = model(r.instr, r.a, r.b, r.imm);
        sb.push_back(e);
        @(negedge clk);
        pa = alu_a;
        pb = alu_b;
        pc = alu_ctrl;
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_instr = r.instr;
        bus.in_rs1   = r.a;
        bus.in_rs2   = r.b;
        bus.in_imm   = r.imm;
        t0 = cyc;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        seen = -1;
        for (int i = 1; i <= 8 && seen < 0; i++) begin
            @(negedge clk);
            if (i == 1 && !e.illegal) begin
                check("alu_ctrl_issue", alu_ctrl, e.ctrl);
                check("alu_a_issue", alu_a, r.a);
            end
            if (bus.out_valid) seen = cyc;
        end
        if (seen < 0) begin
            check("out_valid_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        check("latency", seen - t0, e.illegal ? 1 : 2);
        if (e.illegal) begin
            check("illegal_keeps_alu_a", alu_a, pa);
            check("illegal_keeps_alu_b", alu_b, pb);
            check("illegal_keeps_ctrl", alu_ctrl, pc);
        end
        sr = bus.out_result;
        st = bus.out_branch_taken;
        si = bus.out_illegal;
        for (int i = 0; i < r.hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_stable", {bus.out_result, bus.out_branch_taken, bus.out_illegal}, {sr, st, si});
        end
        bus.out_ready = 1'b1;
        e = sb.pop_front();
        check("out_result", bus.out_result, e.result);
        check("out_taken", bus.out_branch_taken, e.taken);
        check("out_illegal", bus.out_illegal, e.illegal);
        @(posedge clk);
        n_done++;
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.in_imm    = 32'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_result", bus.out_result, 0);
        check("rst_taken", bus.out_branch_taken, 0);
        check("rst_illegal", bus.out_illegal, 0);
        check("rst_alu_ab", {alu_a, alu_b}, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_perf", perf_count, 0);
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            run_req(tbl[k]);
            if (k == 2) begin
                @(negedge clk);
                check("perf_after_3", perf_count, PERF_ON ? 32'd3 : 32'd0);
            end
        end
        @(negedge clk);
        check("perf_all", perf_count, PERF_ON ? 32'(n_done) : 32'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h002081B3;
        bus.in_rs1   = 32'd1;
        bus.in_rs2   = 32'd2;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("issue_before_rst", bus.in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_issue_out_valid", bus.out_valid, 0);
        check("rst_issue_in_ready", bus.in_ready, 1);
        check("rst_issue_perf", perf_count, 0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", bus.out_valid, 0);
        end
        run_req(tbl[0]);
        @(negedge clk);
        check("perf_after_rst", perf_count, PERF_ON ? 32'(n_done) : 32'd0);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
